priority_encoder_rr: RTL and testbench
======================================

PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 The block SHALL have parameter N, default 8: number of request lines, legal range N >= 2.
REQ-002 The block SHALL have derived constant W = clog2(N): index width, 3 for N=8.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port req  input  N  request lines, one-cycle pulses or held levels.
REQ-006 The block SHALL have port mode  input  1  0 = fixed priority with lowest index winning; 1 = round-robin.
REQ-007 The block SHALL have port out_idx  output  W  encoded index of the granted request.
REQ-008 The block SHALL have port out_valid  output  1  out_idx holds a granted request.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts out_idx this cycle.

Function
REQ-010 The block SHALL hold an N-bit pending register P. Each clock edge, C = P | req forms the candidate set.
REQ-011 The block SHALL assert load = !out_valid || out_ready.
REQ-012 On load with C != 0, the block SHALL register out_idx = pick(C), set out_valid = 1 and set P = C & ~onehot(pick(C)).
REQ-013 On load with C == 0, the block SHALL set out_valid = 0, hold out_idx and set P = C.
REQ-014 Without load, the block SHALL hold out_idx and out_valid and set P = C, so no request is ever lost.
REQ-015 Fixed mode SHALL set pick(C) to the lowest set index of C, consistent with the one-hot encoding (bit k -> k).
REQ-016 Round-robin mode SHALL set pick(C) to the first set index at or above pointer ptr, wrapping from N-1 to 0.
REQ-017 ptr SHALL update to (granted index + 1) mod N on every grant in either mode; for N not a power of two, the wrap SHALL be N-1 -> 0.
REQ-018 A change of mode SHALL take effect at the next load; ptr SHALL be retained across mode changes.
REQ-019 Latency SHALL be 1 cycle from req sampled to out_valid, with output empty or accepted.
REQ-020 Throughput SHALL be one grant per cycle while out_ready = 1.
REQ-021 A handshake SHALL complete on any edge with out_valid && out_ready. Under out_valid && !out_ready, out_idx and out_valid SHALL remain stable.
REQ-022 A req bit equal to the index currently presented SHALL become pending again and be granted a second time.
REQ-023 Simultaneous acceptance and new req on the same cycle SHALL be handled by REQ-012 with no bubble.

Reset
REQ-024 rst SHALL, asynchronously and immediately: set out_valid = 0, out_idx = 0, P = 0, ptr = 0.
REQ-025 Reset mid-operation SHALL discard the presented grant and all pending requests.
REQ-026 The first grant after rst deasserts SHALL use req sampled on the first active edge.

Structure
REQ-027 A shared package SHALL hold the mode encodings (MODE_FIXED = 0, MODE_RR = 1) and the index-width function.
REQ-028 The pick function SHALL be one combinational sub-module, prio_pick (inputs C, ptr, mode; outputs idx, any). All state SHALL stay in priority_encoder_rr.

Verification
REQ-029 N=8, fixed: rst, then req=8'b00000001 for 1 cycle, out_ready=1 -> next cycle out_valid=1 with out_idx=0; cycle after -> out_valid=0.
REQ-030 N=8, fixed: req=8'b10010000 for 1 cycle, out_ready=1 -> out_idx 4 then 7 on consecutive cycles; then out_valid=0.
REQ-031 N=8: out_ready=0, req=8'b00000100 pulse -> out_idx=2 with out_valid stable for 5 cycles; then raise out_ready -> next cycle out_valid=0 and P=0.
REQ-032 N=8, RR: req=8'hFF held, out_ready=1 -> out_idx sequence 0,1,2,...,7,0,1 with no gaps.
REQ-033 Mid-operation reset: out_valid=1 and P=8'b01100000, assert rst between edges -> out_valid=0 immediately; after release with req=0 -> out_valid stays 0.
REQ-034 N=5, RR: req=5'b10001 held -> out_idx 0,4,0,4 (wrap 4 -> 0); W=3 and out_idx never exceeds 4.

Source files
------------

// File: rtl/priority_encoder_rr_pkg.sv
// priority_encoder_rr_pkg
// Shared definitions for the priority encoder slice: mode encodings and the
// index-width helper used to size out_idx and the round-robin pointer.
package priority_encoder_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;  // lowest set index wins
    localparam logic MODE_RR    = 1'b1;  // first set index at or above the pointer wins

    // Width of an index into n request lines; never below 1 bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/priority_encoder_rr_if.sv
// priority_encoder_rr_if
// Request/grant bundle between a requester/consumer and priority_encoder_rr.
//   req       : N request lines (pulses or held levels)
//   mode      : MODE_FIXED or MODE_RR
//   out_idx   : granted index (W bits)
//   out_valid : out_idx holds a grant
//   out_ready : consumer accepts out_idx this cycle
// Modports: master = requester/consumer side, slave = encoder side.
interface priority_encoder_rr_if
    import priority_encoder_rr_pkg::*;
#(
    parameter int unsigned N = 8
);
    localparam int unsigned W = idx_width(N);

    logic [N-1:0] req;
    logic         mode;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output req,
        output mode,
        output out_ready,
        input  out_idx,
        input  out_valid
    );

    modport slave (
        input  req,
        input  mode,
        input  out_ready,
        output out_idx,
        output out_valid
    );

endinterface

// File: rtl/priority_encoder_rr_prio_pick.sv
// prio_pick
// Purely combinational pick over the candidate set.
//   c_i   : candidate set (N bits)
//   ptr_i : round-robin start index (W bits, always < N)
//   mode_i: MODE_FIXED scans from 0, MODE_RR scans from ptr_i with wrap
//   idx_o : chosen index (0 when nothing is set)
//   any_o : at least one candidate bit is set
module prio_pick
    import priority_encoder_rr_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] c_i,
    input  logic [W-1:0] ptr_i,
    input  logic         mode_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Fixed priority is the round-robin scan started at index 0.
    always_comb begin
        int unsigned start;
        int unsigned j;
        idx_o = '0;
        any_o = 1'b0;
        start = (mode_i == MODE_RR) ? int'(ptr_i) : 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = start + i;
            if (j >= N) begin
                j = j - N;
            end
            if (c_i[W'(j)] && !any_o) begin
                idx_o = W'(j);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr
// Registered priority encoder with a pending-request register, so no request
// pulse is lost while the output is stalled. Fixed or round-robin priority.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : priority_encoder_rr_if slave (req, mode, out_ready in; out_idx, out_valid out)
module priority_encoder_rr
    import priority_encoder_rr_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input logic                 clk,
    input logic                 rst,
    priority_encoder_rr_if.slave bus
);

    localparam int unsigned W = idx_width(N);

    logic [N-1:0] p_q, p_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx_q, idx_d;
    logic         valid_q, valid_d;

    logic [N-1:0] cand;
    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic         load;

    assign cand = p_q | bus.req;
    assign load = !valid_q || bus.out_ready;

    prio_pick #(
        .N (N)
    ) u_pick (
        .c_i    (cand),
        .ptr_i  (ptr_q),
        .mode_i (bus.mode),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        // Everything not granted this edge stays pending, including a new
        // request for the index currently presented.
        p_d     = cand;
        if (load) begin
            if (pick_any) begin
                idx_d   = pick_idx;
                valid_d = 1'b1;
                p_d     = cand & ~({{(N-1){1'b0}}, 1'b1} << pick_idx);
                ptr_d   = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out_idx   = idx_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr
// Directed stimulus on an N=8 and an N=5 instance. Expected grants are queued
// when stimulus is issued; per-instance monitors pop and compare on every
// out_valid && out_ready handshake.
module tb_priority_encoder_rr;
    import priority_encoder_rr_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    priority_encoder_rr_if #(.N(8)) if8 ();
    priority_encoder_rr_if #(.N(5)) if5 ();

    priority_encoder_rr #(.N(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    priority_encoder_rr #(.N(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (if5)
    );

    int unsigned q8[$];
    int unsigned q5[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake completes on the next rising edge; sample mid-cycle.
    always @(negedge clk) begin
        if (rst == 1'b0 && if8.out_valid && if8.out_ready) begin
            if (q8.size() == 0) begin
                check("grant8_unexpected", {29'd0, if8.out_idx}, 32'hFFFF_FFFF);
            end else begin
                check("grant8", {29'd0, if8.out_idx}, q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst == 1'b0 && if5.out_valid && if5.out_ready) begin
            check("idx5_range", {31'd0, (if5.out_idx <= 3'd4)}, 32'd1);
            if (q5.size() == 0) begin
                check("grant5_unexpected", {29'd0, if5.out_idx}, 32'hFFFF_FFFF);
            end else begin
                check("grant5", {29'd0, if5.out_idx}, q5.pop_front());
            end
        end
    end

    initial begin
        int unsigned rr_seq[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0};

        rst           = 1'b1;
        if8.req       = '0;
        if8.mode      = MODE_FIXED;
        if8.out_ready = 1'b1;
        if5.req       = '0;
        if5.mode      = MODE_FIXED;
        if5.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_valid", {31'd0, if8.out_valid}, 0);
        check("rst_idx", {29'd0, if8.out_idx}, 0);
        step();
        step();

        // Single request, first grant from the first edge after release
        rst     = 1'b0;
        if8.req = 8'h01;
        q8.push_back(0);
        step();
        if8.req = '0;
        step();
        check("single_empty", {31'd0, if8.out_valid}, 0);

        // Two simultaneous requests drain lowest first
        if8.req = 8'h90;
        q8.push_back(4);
        q8.push_back(7);
        step();
        if8.req = '0;
        step();
        step();
        check("pair_empty", {31'd0, if8.out_valid}, 0);

        // Re-request of the presented index is granted again, no bubble
        if8.req = 8'h01;
        q8.push_back(0);
        q8.push_back(0);
        step();
        step();
        if8.req = '0;
        step();
        check("rereq_empty", {31'd0, if8.out_valid}, 0);

        // Stall: output held stable while out_ready is low
        if8.out_ready = 1'b0;
        if8.req       = 8'h04;
        q8.push_back(2);
        step();
        if8.req = '0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, if8.out_valid}, 1);
            check("stall_idx", {29'd0, if8.out_idx}, 2);
            step();
        end
        if8.out_ready = 1'b1;
        step();
        check("stall_release_valid", {31'd0, if8.out_valid}, 0);
        check("stall_release_p", {24'd0, dut8.p_q}, 0);

        // Mid-operation reset discards presented grant and pending set
        if8.out_ready = 1'b0;
        if8.req       = 8'h70;
        step();
        if8.req = '0;
        check("pre_rst_valid", {31'd0, if8.out_valid}, 1);
        check("pre_rst_idx", {29'd0, if8.out_idx}, 4);
        check("pre_rst_p", {24'd0, dut8.p_q}, 32'h60);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, if8.out_valid}, 0);
        check("async_rst_idx", {29'd0, if8.out_idx}, 0);
        check("async_rst_p", {24'd0, dut8.p_q}, 0);
        step();
        rst           = 1'b0;
        if8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle", {31'd0, if8.out_valid}, 0);
        end

        // Round-robin with all lines held, then drain of the pending set
        if8.mode = MODE_RR;
        if8.req  = 8'hFF;
        foreach (rr_seq[i]) q8.push_back(rr_seq[i]);
        repeat (10) step();
        if8.req = '0;
        for (int i = 0; i < 50 && q8.size() != 0; i++) step();
        check("drain8", q8.size(), 0);
        step();
        check("rr_empty", {31'd0, if8.out_valid}, 0);

        // N=5 round-robin wrap 4 -> 0
        if5.mode = MODE_RR;
        if5.req  = 5'b10001;
        q5.push_back(0);
        q5.push_back(4);
        q5.push_back(0);
        q5.push_back(4);
        q5.push_back(0);
        repeat (4) step();
        if5.req = '0;
        for (int i = 0; i < 50 && q5.size() != 0; i++) step();
        check("drain5", q5.size(), 0);
        step();
        check("n5_empty", {31'd0, if5.out_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
